// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor/request widths, panel timing constants,
// floor codes, the call-panel state enum and the floor controller's direction enum.
package elevator_pkg;

    localparam int unsigned N_FLOORS = 5;
    localparam int unsigned FLOOR_W  = 3;
    localparam int unsigned SETTLE   = 3;
    localparam int unsigned DWELL    = 8;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [FLOOR_W-1:0] {
        FLOOR_A = 3'd0,
        FLOOR_B = 3'd1,
        FLOOR_C = 3'd2,
        FLOOR_D = 3'd3,
        FLOOR_E = 3'd4
    } floor_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } panel_state_e;

    // Direction of travel used by the floor controller.
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/elevator_call_panel_if.sv
// Call panel <-> floor controller bundle.
//   btn       : raw call buttons (one per floor)
//   floor     : current floor code from the controller
//   req       : held requests toward the controller
//   door_open : door open indication
//   pending   : any request held
// master = controller/button side, slave = call panel.
interface elevator_call_panel_if;
    import elevator_pkg::*;

    logic [N_FLOORS-1:0] btn;
    logic [FLOOR_W-1:0]  floor;
    logic [N_FLOORS-1:0] req;
    logic                door_open;
    logic                pending;

    modport master (
        output btn,
        output floor,
        input  req,
        input  door_open,
        input  pending
    );

    modport slave (
        input  btn,
        input  floor,
        output req,
        output door_open,
        output pending
    );

endinterface

// File: rtl/ec_dwell_timer.sv
// Loadable down-counter for the door dwell time.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over en)
//   en         : decrement by one, stops at zero
//   load_val   : reload value
//   zero_c     : counter is zero (combinational from the register)
module ec_dwell_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel: latches call-button presses into held requests, waits for the
// controller's floor to settle, opens the door at a requested floor for the
// dwell time, then clears that floor's request.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of elevator_call_panel_if (btn, floor in; req, door_open,
//          pending out). req and door_open are registered, pending is |req.
module elevator_call_panel
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    elevator_call_panel_if.slave  bus
);

    logic [N_FLOORS-1:0] btn_q, btn_d;
    logic [N_FLOORS-1:0] req_q, req_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic                door_open_q, door_open_d;
    panel_state_e        state_q, state_d;

    logic [N_FLOORS-1:0] press;
    logic [N_FLOORS-1:0] floor_mask;
    logic                settled;
    logic                hit_req;
    logic                hit_press;
    logic                dwell_load;
    logic                dwell_en;
    logic                dwell_zero;

    assign press      = bus.btn & ~btn_q;
    // One-hot of the sampled floor; an out-of-range code shifts out to all-zero.
    assign floor_mask = N_FLOORS'(1) << floor_q;
    assign settled    = (settle_cnt_q == CNT_W'(SETTLE));
    assign hit_req    = |(req_q & floor_mask);
    assign hit_press  = |(press & floor_mask);

    ec_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst),
        .load     (dwell_load),
        .en       (dwell_en),
        .load_val (CNT_W'(DWELL - 1)),
        .zero_c   (dwell_zero)
    );

    // Capture, settle and door FSM next-state logic.
    always_comb begin
        btn_d        = bus.btn;
        floor_d      = bus.floor;
        req_d        = req_q | press;
        settle_cnt_d = settle_cnt_q;
        door_open_d  = door_open_q;
        state_d      = state_q;
        dwell_load   = 1'b0;
        dwell_en     = 1'b0;

        if ((bus.floor != floor_q) || (bus.floor >= FLOOR_W'(N_FLOORS))) begin
            settle_cnt_d = '0;
        end else if (!settled) begin
            settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (settled && hit_req) begin
                    state_d     = OPEN;
                    door_open_d = 1'b1;
                    dwell_load  = 1'b1;
                end
            end
            OPEN: begin
                if (bus.floor != floor_q) begin
                    // Car moved with the door open: abandon, keep requests.
                    state_d     = IDLE;
                    door_open_d = 1'b0;
                end else if (hit_press) begin
                    dwell_load = 1'b1;
                end else if (dwell_zero) begin
                    state_d = CLOSE;
                end else begin
                    dwell_en = 1'b1;
                end
            end
            CLOSE: begin
                // A fresh press on this floor in the same cycle keeps its bit.
                req_d        = (req_q & ~floor_mask) | press;
                door_open_d  = 1'b0;
                settle_cnt_d = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d     = IDLE;
                door_open_d = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q        <= '0;
            req_q        <= '0;
            floor_q      <= '0;
            settle_cnt_q <= '0;
            door_open_q  <= 1'b0;
            state_q      <= IDLE;
        end else begin
            btn_q        <= btn_d;
            req_q        <= req_d;
            floor_q      <= floor_d;
            settle_cnt_q <= settle_cnt_d;
            door_open_q  <= door_open_d;
            state_q      <= state_d;
        end
    end

    assign bus.req       = req_q;
    assign bus.door_open = door_open_q;
    assign bus.pending   = |req_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Scoreboard bench for elevator_call_panel: directed steps push hand-computed
// req/door_open values; a negedge monitor pops and compares.
module tb_elevator_call_panel;

    logic clk;
    logic rst;

    elevator_call_panel_if bus ();

    elevator_call_panel dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0] req;
        logic       door;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [4:0] er, input logic ed);
        n_vec++;
        if ((bus.req !== er) || (bus.door_open !== ed) || (bus.pending !== (|er))) begin
            n_miss++;
            $display("FAIL %s: got req=%b door_open=%b pending=%b, expected req=%b door_open=%b pending=%b",
                     nm, bus.req, bus.door_open, bus.pending, er, ed, |er);
        end
    endtask

    // Monitor: compare outputs after every edge that has an expectation queued.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.nm, e.req, e.door);
        end
    end

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    task automatic step(input logic [4:0] b, input logic [2:0] f,
                        input logic [4:0] er, input logic ed, input string nm);
        exp_t e;
        bus.btn   = b;
        bus.floor = f;
        @(posedge clk);
        e.req  = er;
        e.door = ed;
        e.nm   = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic [4:0] b, input logic [2:0] f,
                        input logic [4:0] er, input logic ed, input string nm);
        for (int i = 0; i < n; i++) begin
            step(b, f, er, ed, nm);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b0;
        bus.btn   = '0;
        bus.floor = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 5'b00000, 1'b0);
        rst = 1'b1;

        // Open at floor 2 with req 00110, then reset asynchronously mid-OPEN.
        step(5'b00110, 3'd2, 5'b00110, 1'b0, "p1_press");
        hold(3, 5'b00000, 3'd2, 5'b00110, 1'b0, "p1_settle");
        step(5'b00000, 3'd2, 5'b00110, 1'b1, "p1_open");
        step(5'b00000, 3'd2, 5'b00110, 1'b1, "p1_dwell");
        #2 rst = 1'b0;
        #1 check("async_reset", 5'b00000, 1'b0);
        bus.btn   = '0;
        bus.floor = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Capture: single pulse, then a long hold sets only once.
        step(5'b01000, 3'd0, 5'b01000, 1'b0, "cap_pulse");
        step(5'b00000, 3'd0, 5'b01000, 1'b0, "cap_release");
        hold(10, 5'b01000, 3'd0, 5'b01000, 1'b0, "cap_hold");
        step(5'b00000, 3'd0, 5'b01000, 1'b0, "cap_hold_rel");

        // Arrival at floor 2: settle, dwell, close clears req[2].
        step(5'b00100, 3'd2, 5'b01100, 1'b0, "arr_press");
        hold(3, 5'b00000, 3'd2, 5'b01100, 1'b0, "arr_settle");
        step(5'b00000, 3'd2, 5'b01100, 1'b1, "arr_open");
        hold(7, 5'b00000, 3'd2, 5'b01100, 1'b1, "arr_dwell");
        step(5'b00000, 3'd2, 5'b01100, 1'b1, "arr_close_state");
        step(5'b00000, 3'd2, 5'b01000, 1'b0, "arr_clear");
        hold(4, 5'b00000, 3'd2, 5'b01000, 1'b0, "arr_idle");

        // Dwell extend: re-press floor 2 when the dwell count is 1.
        step(5'b00100, 3'd2, 5'b01100, 1'b0, "ext_press");
        step(5'b00000, 3'd2, 5'b01100, 1'b1, "ext_open");
        hold(6, 5'b00000, 3'd2, 5'b01100, 1'b1, "ext_dwell");
        step(5'b00100, 3'd2, 5'b01100, 1'b1, "ext_repress");
        hold(7, 5'b00000, 3'd2, 5'b01100, 1'b1, "ext_dwell2");
        step(5'b00000, 3'd2, 5'b01100, 1'b1, "ext_close_state");
        step(5'b00000, 3'd2, 5'b01000, 1'b0, "ext_clear");

        // Bounce between floors 1/2, then an out-of-range floor: never opens.
        step(5'b00100, 3'd1, 5'b01100, 1'b0, "bnc_press");
        for (int i = 0; i < 5; i++) begin
            step(5'b00000, (i % 2 == 0) ? 3'd2 : 3'd1, 5'b01100, 1'b0, "bnc_toggle");
        end
        hold(7, 5'b00000, 3'd6, 5'b01100, 1'b0, "bnc_oor");

        // Race at floor 4: press in the CLOSE cycle keeps req[4]; btn[0] meanwhile.
        step(5'b10000, 3'd4, 5'b11100, 1'b0, "race_press");
        hold(3, 5'b00000, 3'd4, 5'b11100, 1'b0, "race_settle");
        step(5'b00000, 3'd4, 5'b11100, 1'b1, "race_open");
        hold(7, 5'b00000, 3'd4, 5'b11100, 1'b1, "race_dwell");
        step(5'b00000, 3'd4, 5'b11100, 1'b1, "race_close_state");
        step(5'b10000, 3'd4, 5'b11100, 1'b0, "race_repress");
        step(5'b00001, 3'd4, 5'b11101, 1'b0, "race_btn0");
        hold(2, 5'b00000, 3'd4, 5'b11101, 1'b0, "race_resettle");
        step(5'b00000, 3'd4, 5'b11101, 1'b1, "race_reopen");
        step(5'b00000, 3'd4, 5'b11101, 1'b1, "race_dwell");

        // Car moves while open: door drops, requests kept, opens at floor 3.
        step(5'b00000, 3'd3, 5'b11101, 1'b0, "fault_move");
        hold(3, 5'b00000, 3'd3, 5'b11101, 1'b0, "fault_settle");
        step(5'b00000, 3'd3, 5'b11101, 1'b1, "fault_reopen");

        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
